decode_stage: RTL and testbench

Registered, parametrised instruction-decode stage that sits between fetch and EX. It decodes the ADD/SUB/AND/OR/MUL/LW/SW subset into register-read addresses and the EX control word, then holds the result in a valid/ready pipeline register. A load-use scoreboard inserts bubbles automatically. Unknown encodings are turned into flagged NOPs, and hazard bubbles are counted.

---
 rtl/decode_stage_if.sv | 28 ++
 rtl/decode_stage.sv | 201 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and EX-side handshake bundle for decode_stage
`timescale 1ns/1ps

interface decode_stage_if;
  // fetch side
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  // EX side
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  a_reg;
  logic [4:0]  b_reg;
  logic [11:0] ctrl_ex;
  logic        illegal;

  // environment view: drives instructions and EX back-pressure
  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, a_reg, b_reg, ctrl_ex, illegal
  );

  // decode stage view
  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, a_reg, b_reg, ctrl_ex, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode with load-use scoreboard and bubble counter
`timescale 1ns/1ps

module decode_stage #(
  parameter int LOAD_LAT = 1,
  parameter int EN_MUL   = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt
);

  // ctrl_ex = {c_sel, d_sel, op_sel[1:0], wr_rd, wb_sel, wb_en, wb_reg[4:0]}
  localparam logic [11:0] NOP_CTRL = 12'b1_1_11_1_0_0_00000;

  localparam logic [5:0] OP_R  = 6'd2;
  localparam logic [5:0] OP_LW = 6'd3;
  localparam logic [5:0] OP_SW = 6'd4;
  localparam logic [4:0] F1_R  = 5'd10;

  // instruction fields
  logic [5:0] op;
  logic [4:0] rs, rt, rd, f1;
  logic [5:0] f2;

  assign op = bus.instr[31:26];
  assign rs = bus.instr[25:21];
  assign rt = bus.instr[20:16];
  assign rd = bus.instr[15:11];
  assign f1 = bus.instr[10:6];
  assign f2 = bus.instr[5:0];

  // decode results
  logic [4:0]  dec_a, dec_b;
  logic [11:0] dec_ctrl;
  logic        dec_ill;
  logic        dec_lw;
  logic        use_rs, use_rt;
  logic        r_ok;
  logic        r_dsel;
  logic [1:0]  r_opsel;

  // held pipeline register
  logic        out_valid_q;
  logic [4:0]  a_q, b_q;
  logic [11:0] ctrl_q;
  logic        illegal_q;

  // load-use scoreboard: entry i holds an LW destination issued i+1 slots ago
  logic [LOAD_LAT-1:0] sb_v;
  logic [4:0]          sb_reg [LOAD_LAT];

  logic rs_hit, rt_hit;
  logic hazard;
  logic advance;
  logic load_valid;

  // combinational decode of the presented instruction
  always_comb begin
    dec_a    = 5'd0;
    dec_b    = 5'd0;
    dec_ctrl = NOP_CTRL;
    dec_ill  = 1'b0;
    dec_lw   = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    r_ok     = 1'b0;
    r_dsel   = 1'b1;
    r_opsel  = 2'd0;
    case (op)
      OP_R: begin
        // op 2 with any other f1 is a silent NOP
        if (f1 == F1_R) begin
          case (f2)
            6'd32: begin r_ok = 1'b1; r_dsel = 1'b1; r_opsel = 2'd0; end
            6'd34: begin r_ok = 1'b1; r_dsel = 1'b1; r_opsel = 2'd1; end
            6'd36: begin r_ok = 1'b1; r_dsel = 1'b1; r_opsel = 2'd2; end
            6'd37: begin r_ok = 1'b1; r_dsel = 1'b1; r_opsel = 2'd3; end
            6'd50: begin
              r_ok    = (EN_MUL != 0);
              r_dsel  = 1'b0;
              r_opsel = 2'd0;
            end
            default: r_ok = 1'b0;
          endcase
          if (r_ok) begin
            dec_a    = rs;
            dec_b    = rt;
            dec_ctrl = {1'b0, r_dsel, r_opsel, 1'b1, 1'b0, 1'b1, rd};
            use_rs   = 1'b1;
            use_rt   = 1'b1;
          end else begin
            dec_ill  = 1'b1;
          end
        end
      end
      OP_LW: begin
        dec_a    = rs;
        dec_b    = 5'd0;
        dec_ctrl = {1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, rt};
        dec_lw   = 1'b1;
        use_rs   = 1'b1;
      end
      OP_SW: begin
        dec_a    = rs;
        dec_b    = rt;
        dec_ctrl = {1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 5'd0};
        use_rs   = 1'b1;
        use_rt   = 1'b1;
      end
      default: ;
    endcase
  end

  // compare used sources against every in-flight load destination
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_v[i] && (sb_reg[i] == rs)) rs_hit = 1'b1;
      if (sb_v[i] && (sb_reg[i] == rt)) rt_hit = 1'b1;
    end
  end

  // r0 is never a real dependency
  assign hazard = bus.in_valid &&
                  ((use_rs && (rs != 5'd0) && rs_hit) ||
                   (use_rt && (rt != 5'd0) && rt_hit));

  assign advance    = !out_valid_q || bus.out_ready;
  assign load_valid = bus.in_valid && !hazard;

  assign bus.in_ready  = advance && !hazard && !flush;
  assign bus.out_valid = out_valid_q;
  assign bus.a_reg     = a_q;
  assign bus.b_reg     = b_q;
  assign bus.ctrl_ex   = ctrl_q;
  assign bus.illegal   = illegal_q;

  // pipeline register: flush kills the slot, hold freezes it, advance loads decode or a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      a_q         <= 5'd0;
      b_q         <= 5'd0;
      ctrl_q      <= NOP_CTRL;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      a_q         <= 5'd0;
      b_q         <= 5'd0;
      ctrl_q      <= NOP_CTRL;
      illegal_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= load_valid;
      a_q         <= load_valid ? dec_a    : 5'd0;
      b_q         <= load_valid ? dec_b    : 5'd0;
      ctrl_q      <= load_valid ? dec_ctrl : NOP_CTRL;
      illegal_q   <= load_valid && dec_ill;
    end else begin
      // illegal only flags the first cycle the slot is presented
      illegal_q   <= 1'b0;
    end
  end

  // scoreboard shifts once per issued slot (real or bubble), cleared by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v <= '0;
      for (int i = 0; i < LOAD_LAT; i++) sb_reg[i] <= 5'd0;
    end else if (flush) begin
      sb_v <= '0;
      for (int i = 0; i < LOAD_LAT; i++) sb_reg[i] <= 5'd0;
    end else if (advance) begin
      for (int i = 1; i < LOAD_LAT; i++) begin
        sb_v[i]   <= sb_v[i-1];
        sb_reg[i] <= sb_reg[i-1];
      end
      if (load_valid && dec_lw && (rt != 5'd0)) begin
        sb_v[0]   <= 1'b1;
        sb_reg[0] <= rt;
      end else begin
        sb_v[0]   <= 1'b0;
        sb_reg[0] <= 5'd0;
      end
    end
  end

  // saturating count of hazard bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!flush && advance && hazard && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
`timescale 1ns/1ps

module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [15:0] stall_cnt, stall_cnt2;

  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage_if bus2 ();

  decode_stage #(.LOAD_LAT(2), .EN_MUL(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .stall_cnt(stall_cnt)
  );

  // same stream into a MUL-disabled copy
  decode_stage #(.LOAD_LAT(2), .EN_MUL(0), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2), .stall_cnt(stall_cnt2)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.instr     = bus.instr;
  assign bus2.out_ready = bus.out_ready;

  typedef struct {
    logic [4:0]  a;
    logic [4:0]  b;
    logic [11:0] c;
    logic        il;
    logic [11:0] c2;
    logic        il2;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ill_cnt = 0;
  int ill_cnt2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input int op, input int rs, input int rt,
                                     input int rd, input int f1, input int f2);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], rd[4:0], f1[4:0], f2[5:0]};
    return w;
  endfunction

  function automatic exp_t ex(input logic [4:0] a, input logic [4:0] b, input logic [11:0] c,
                              input logic il, input logic [11:0] c2, input logic il2);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.il = il; e.c2 = c2; e.il2 = il2;
    return e;
  endfunction

  function automatic exp_t ex1(input logic [4:0] a, input logic [4:0] b,
                               input logic [11:0] c, input logic il);
    return ex(a, b, c, il, c, il);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // present instr until accepted; push expectation at the accepting edge
  task automatic send(input logic [31:0] ins, input exp_t e, output int acc);
    bus.instr = ins;
    bus.in_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e);
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (acc < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: instr %h never accepted", ins);
    end
  endtask

  // monitor: pop and compare on every transfer to EX
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.illegal)  ill_cnt++;
      if (bus2.illegal) ill_cnt2++;
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_slot: got ctrl %h with nothing expected", bus.ctrl_ex);
        end else begin
          me = q.pop_front();
          if ({bus.a_reg, bus.b_reg, bus.ctrl_ex, bus.illegal, bus2.ctrl_ex, bus2.illegal} !==
              {me.a, me.b, me.c, me.il, me.c2, me.il2}) begin
            n_fail++;
            $display("FAIL slot: got a=%0d b=%0d ctrl=%h ill=%b ctrl2=%h ill2=%b expected a=%0d b=%0d ctrl=%h ill=%b ctrl2=%h ill2=%b",
                     bus.a_reg, bus.b_reg, bus.ctrl_ex, bus.illegal, bus2.ctrl_ex, bus2.illegal,
                     me.a, me.b, me.c, me.il, me.c2, me.il2);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, tl, ta, tb, tf;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'd0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_ab", {bus.a_reg, bus.b_reg}, 0);
    check("rst_ctrl", bus.ctrl_ex, 12'hF80);
    check("rst_illegal", bus.illegal, 0);
    check("rst_stall", stall_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // decode coverage, back-to-back
    send(mk(2, 1, 2, 3, 10, 32), ex1(1, 2, 12'h4A3, 0), t0);
    send(mk(2, 1, 2, 4, 10, 34), ex1(1, 2, 12'h5A4, 0), t1);
    check("throughput", t1 - t0, 1);
    send(mk(2, 3, 4, 7, 10, 36), ex1(3, 4, 12'h6A7, 0), t0);
    send(mk(2, 5, 6, 8, 10, 37), ex1(5, 6, 12'h7A8, 0), t0);
    send(mk(2, 1, 2, 9, 10, 50), ex(1, 2, 12'h0A9, 0, 12'hF80, 1), t0);
    send(mk(2, 1, 2, 3, 5, 32), ex1(0, 0, 12'hF80, 0), t0);
    send(mk(7, 1, 2, 3, 10, 32), ex1(0, 0, 12'hF80, 0), t0);
    send(mk(4, 1, 2, 0, 0, 0), ex1(1, 2, 12'hC40, 0), t0);
    send(mk(2, 1, 2, 3, 10, 42), ex1(0, 0, 12'hF80, 1), t0);
    check("stall_idle", stall_cnt, 0);

    // LW r5 then dependent ADD: two bubbles
    send(mk(3, 1, 5, 0, 0, 0), ex1(1, 0, 12'hCE5, 0), tl);
    send(mk(2, 5, 1, 6, 10, 32), ex1(5, 1, 12'h4A6, 0), ta);
    check("lw_use_gap", ta - tl, 3);
    check("stall_lw", stall_cnt, 2);

    // an independent instr fills one of the gap slots
    send(mk(3, 1, 5, 0, 0, 0), ex1(1, 0, 12'hCE5, 0), tl);
    send(mk(4, 1, 2, 0, 0, 0), ex1(1, 2, 12'hC40, 0), t0);
    send(mk(2, 5, 1, 6, 10, 32), ex1(5, 1, 12'h4A6, 0), ta);
    check("lw_indep_gap", ta - tl, 3);
    check("stall_indep", stall_cnt, 3);

    // SW reading the load destination through rt
    send(mk(3, 1, 5, 0, 0, 0), ex1(1, 0, 12'hCE5, 0), tl);
    send(mk(4, 1, 5, 0, 0, 0), ex1(1, 5, 12'hC40, 0), ta);
    check("lw_sw_rt_gap", ta - tl, 3);
    check("stall_sw_rt", stall_cnt, 5);

    // LW into r0 never stalls
    send(mk(3, 1, 0, 0, 0, 0), ex1(1, 0, 12'hCE0, 0), tl);
    send(mk(2, 0, 2, 7, 10, 32), ex1(0, 2, 12'h4A7, 0), ta);
    check("lw_r0_gap", ta - tl, 1);
    check("stall_r0", stall_cnt, 5);

    // hold behind a valid SW
    send(mk(4, 3, 4, 0, 0, 0), ex1(3, 4, 12'hC40, 0), t0);
    bus.out_ready = 1'b0;
    bus.instr = mk(2, 1, 2, 3, 10, 32);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_slot", {bus.out_valid, bus.a_reg, bus.ctrl_ex}, {1'b1, 5'd3, 12'hC40});
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    tb = cyc;
    send(mk(2, 1, 2, 3, 10, 32), ex1(1, 2, 12'h4A3, 0), ta);
    check("hold_release", ta - tb, 1);

    // flush a held LW with a dependent instr waiting
    send(mk(3, 1, 5, 0, 0, 0), ex1(1, 0, 12'hCE5, 0), tl);
    bus.out_ready = 1'b0;
    bus.instr = mk(2, 5, 1, 6, 10, 32);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    q.delete();
    tf = cyc;
    bus.out_ready = 1'b1;
    check("flush_out_valid", bus.out_valid, 0);
    send(mk(2, 5, 1, 6, 10, 32), ex1(5, 1, 12'h4A6, 0), ta);
    check("flush_no_bubble", ta - tf, 1);
    check("flush_stall", stall_cnt, 5);

    // async reset in the middle of a load-use stall
    send(mk(3, 1, 5, 0, 0, 0), ex1(1, 0, 12'hCE5, 0), tl);
    bus.instr = mk(2, 5, 1, 6, 10, 32);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("prereset_stall", stall_cnt, 6);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midrst_slot", {bus.out_valid, bus.a_reg, bus.b_reg, bus.ctrl_ex, bus.illegal},
          {1'b0, 5'd0, 5'd0, 12'hF80, 1'b0});
    check("midrst_stall", stall_cnt, 0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    tb = cyc;
    send(mk(2, 5, 1, 6, 10, 32), ex1(5, 1, 12'h4A6, 0), ta);
    check("postrst_no_bubble", ta - tb, 1);

    repeat (3) @(posedge clk);
    #1;
    check("illegal_pulses", ill_cnt, 1);
    check("illegal_pulses_nomul", ill_cnt2, 2);
    check("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
